regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Debug reader for the CPU register file. On a start pulse it walks register
//  indices, borrowing the register file's read port through a req/gnt
//  arbitration. Each word it reads is streamed out on a valid/ready interface
//  with its index. It sits beside the decode stage; the register file is
//  unchanged, and the CPU keeps priority on the read port.
// PARAMETERS
//  NUM_REGS   32  number of registers walked (indices 0..NUM_REGS-1)
//  ADDR_W      5  register index width
//  DATA_W     32  register data width
//  SKIP_ZERO   0  1: start at index 1 (r0 is hardwired zero, not streamed)
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse, begins a dump; ignored while busy
//  abort      in   1       synchronous cancel of a running dump
//  rd_req     out  1       request for the register file read port
//  rd_gnt     in   1       read port granted; rd_addr is driven this cycle
//  rd_addr    out  ADDR_W  register index presented to the read port
//  rd_data    in   DATA_W  combinational read data returned for rd_addr
//  out_valid  out  1       out_data/out_idx/out_last hold a valid word
//  out_ready  in   1       consumer accepts the word
//  out_data   out  DATA_W  register contents
//  out_idx    out  ADDR_W  register index of out_data
//  out_last   out  1       word belongs to index NUM_REGS-1
//  busy       out  1       dump in progress (state != IDLE)
//  done       out  1       1-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, all outputs 0.
//  FSM IDLE -> READ -> HOLD -> (READ | DONE) -> IDLE:
//   IDLE: start=1 -> READ; idx loads SKIP_ZERO ? 1 : 0.
//   READ: rd_req=1, rd_addr=idx. If rd_gnt=1, the edge latches rd_data,
//         idx and last into the output registers and goes to HOLD.
//         If rd_gnt=0, stay in READ; there is no timeout.
//   HOLD: out_valid=1; outputs stay stable until handshake (valid&ready).
//         On handshake: if idx==NUM_REGS-1 -> DONE, else idx+=1 -> READ.
//   DONE: done=1 for one cycle; out_valid=0 -> IDLE.
//  Throughput: at best 1 word per 2 cycles (READ+gnt, HOLD+ready).
//  Data is sampled only in the rd_gnt cycle, so a later register file write
//  does not alter a word already captured.
//  rd_req is 0 outside READ; rd_addr is held at its last value when idle.
//  abort=1 in any state -> IDLE next edge; out_valid and rd_req drop; no done.
//  Simultaneous abort and start in IDLE: abort wins, no dump starts.
//  start while busy: ignored, no restart.
//  idx never wraps: the terminal compare uses NUM_REGS-1, and idx is ADDR_W wide.
//  Reset mid-dump: immediate return to the reset state; the dump is lost.
// CONFIGURATION
//  REGDUMP_CHECKSUM_EN defined:
//   Adds port checksum (out, DATA_W). It clears at start and adds each
//   accepted out_data modulo 2^DATA_W. It is valid and stable from the done
//   cycle until the next start. Reset value is 0.
//  REGDUMP_CHECKSUM_EN undefined: the port and adder are absent; the rest of
//   the behaviour is identical.
// STRUCTURE
//  Package regdump_pkg: state enum {IDLE, READ, HOLD, DONE} (2-bit),
//   localparam defaults for ADDR_W/DATA_W/NUM_REGS.
//  No sub-module. The FSM, index counter, output register and optional
//   checksum stay inline; the design is small enough for one module.
// TESTING
//  1 Full dump: regs[i]=i*0x11, gnt and ready held at 1, start pulse ->
//    32 words idx 0..31, out_last only on idx 31, done 1 cycle after, 64 cycles.
//  2 SKIP_ZERO=1: start -> first word idx 1; 31 words total; done once.
//  3 Backpressure: out_ready=0 for 5 cycles at idx 7 -> out_data/out_idx
//    stable; no rd_req; idx 8 is read only after accept.
//  4 Grant denial: rd_gnt=0 for 3 cycles at idx 4 -> rd_req=1, rd_addr=4
//    held; a write of 0xDEAD to r4 during the wait is captured after grant.
//  5 Abort at idx 10 with out_valid=1 -> IDLE next cycle, out_valid=0, no done;
//    a new start restarts from idx 0. Reset mid-dump -> outputs 0 at once.
//  6 REGDUMP_CHECKSUM_EN: regs all 0xFFFFFFFF, 32 words ->
//    checksum=0xFFFFFFE0 at done.

Source files
------------

// File: rtl/regdump_pkg.sv
// Shared definitions for the register file dump reader.
//   - default geometry of the register file being walked
//   - FSM state encoding
package regdump_pkg;

  localparam int unsigned RegdumpNumRegs = 32;
  localparam int unsigned RegdumpAddrW   = 5;
  localparam int unsigned RegdumpDataW   = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Debug reader that walks the CPU register file and streams each word out.
// On a start pulse it borrows the register file read port via rd_req/rd_gnt
// (the CPU keeps priority), captures the word in the grant cycle and presents
// it with its index on a valid/ready stream. One word per two cycles at best.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          begin a dump (ignored while busy) / cancel a dump
//   rd_req, rd_gnt        read port request / grant
//   rd_addr, rd_data      register index presented, combinational read data
//   out_valid, out_ready  output stream handshake
//   out_data, out_idx     captured register word and its index
//   out_last              word belongs to index NUM_REGS-1
//   busy, done            dump in progress / 1-cycle pulse after last accept
//   checksum              sum of accepted words mod 2^DATA_W
//                         (only when REGDUMP_CHECKSUM_EN is defined)
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int unsigned NUM_REGS  = RegdumpNumRegs,
  parameter int unsigned ADDR_W    = RegdumpAddrW,
  parameter int unsigned DATA_W    = RegdumpDataW,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);
  // r0 is hardwired zero, so it can be skipped.
  localparam logic [ADDR_W-1:0] FirstIdx = SKIP_ZERO ? ADDR_W'(1) : ADDR_W'(0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oidx_q, oidx_d;
  logic              last_q, last_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
    // Abort overrides everything, including a start in the same cycle.
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StRead;
            idx_d   = FirstIdx;
          end
        end
        StRead: begin
          // Data is sampled only in the grant cycle; later writes don't touch it.
          if (rd_gnt) begin
            data_d  = rd_data;
            oidx_d  = idx_q;
            last_d  = (idx_q == LastIdx);
            state_d = StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            if (idx_q == LastIdx) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = StRead;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
    end
  end

  // Moore outputs; rd_addr keeps the last index while idle.
  assign rd_req    = (state_q == StRead);
  assign rd_addr   = idx_q;
  assign out_valid = (state_q == StHold);
  assign out_data  = data_q;
  assign out_idx   = oidx_q;
  assign out_last  = last_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (!abort) begin
      if (state_q == StIdle && start) begin
        sum_d = '0;
      end else if (state_q == StHold && out_ready) begin
        sum_d = sum_q + data_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: stimulus pushes expected words,
// negedge monitors pop and compare on each output handshake.
module tb_regfile_dump_reader;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned AddrW   = 5;
  localparam int unsigned DataW   = 32;

  typedef struct packed {
    logic [AddrW-1:0] idx;
    logic [DataW-1:0] data;
    logic             last;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, gnt = 1'b1, ready = 1'b1;
  logic start_s = 1'b0, abort_s = 1'b0, gnt_s = 1'b1, ready_s = 1'b1;
  logic [DataW-1:0] regs [NumRegs];

  logic             rd_req, out_valid, out_last, busy, done;
  logic [AddrW-1:0] rd_addr, out_idx;
  logic [DataW-1:0] rd_data, out_data;
  logic             rd_req_s, out_valid_s, out_last_s, busy_s, done_s;
  logic [AddrW-1:0] rd_addr_s, out_idx_s;
  logic [DataW-1:0] rd_data_s, out_data_s;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DataW-1:0] checksum, checksum_s;
`endif

  assign rd_data   = regs[rd_addr];
  assign rd_data_s = regs[rd_addr_s];

  always #5 clk = ~clk;

  regfile_dump_reader #(.NUM_REGS(NumRegs), .ADDR_W(AddrW), .DATA_W(DataW), .SKIP_ZERO(1'b0))
  dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_req(rd_req), .rd_gnt(gnt), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef REGDUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  regfile_dump_reader #(.NUM_REGS(NumRegs), .ADDR_W(AddrW), .DATA_W(DataW), .SKIP_ZERO(1'b1))
  dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
    .rd_req(rd_req_s), .rd_gnt(gnt_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .out_valid(out_valid_s), .out_ready(ready_s), .out_data(out_data_s), .out_idx(out_idx_s),
    .out_last(out_last_s), .busy(busy_s), .done(done_s)
`ifdef REGDUMP_CHECKSUM_EN
    , .checksum(checksum_s)
`endif
  );

  word_t exp_q[$];
  word_t exp_s[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue a full expected dump with data i*0x11, optionally overriding r4.
  task automatic push_dump(input bit skip, input logic [DataW-1:0] r4);
    word_t w;
    for (int i = (skip ? 1 : 0); i < NumRegs; i++) begin
      w.idx  = AddrW'(i);
      w.data = (i == 4) ? r4 : DataW'(i * 17);
      w.last = (i == NumRegs - 1);
      if (skip) exp_s.push_back(w);
      else      exp_q.push_back(w);
    end
  endtask

  task automatic wait_done(input bit s, input int budget, output int cyc);
    cyc = 0;
    while (!(s ? done_s : done) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!(s ? done_s : done)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done(%0d): no done within %0d cycles", s, budget);
    end
  endtask

  // Monitor for the SKIP_ZERO=0 instance.
  initial begin
    bit    stall_prev = 1'b0;
    bit    done_pend  = 1'b0;
    word_t held, got, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        done_pend  = 1'b0;
      end else begin
        if (done_pend || done) chk("done_pulse", 64'(done), 64'(done_pend));
        done_pend = 1'b0;
        got = {out_idx, out_data, out_last};
        if (stall_prev && out_valid) begin
          chk("stall_stable", 64'(got), 64'(held));
          chk("stall_no_req", 64'(rd_req), 64'd0);
        end
        stall_prev = out_valid && !ready;
        held       = got;
        if (out_valid && ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got idx %0d data 0x%0h", out_idx, out_data);
          end else begin
            e = exp_q.pop_front();
            chk("word", 64'(got), 64'(e));
            done_pend = e.last;
          end
        end
      end
    end
  end

  // Monitor for the SKIP_ZERO=1 instance.
  initial begin
    bit    done_pend = 1'b0;
    word_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_pend = 1'b0;
      end else begin
        if (done_pend || done_s) chk("skip_done_pulse", 64'(done_s), 64'(done_pend));
        done_pend = 1'b0;
        if (out_valid_s && ready_s) begin
          if (exp_s.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL skip_unexpected_word: got idx %0d", out_idx_s);
          end else begin
            e = exp_s.pop_front();
            chk("skip_word", 64'({out_idx_s, out_data_s, out_last_s}), 64'(e));
            done_pend = e.last;
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    int t;
    for (int i = 0; i < NumRegs; i++) regs[i] = DataW'(i * 17);

    // Reset state
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_req", 64'(rd_req), 64'd0);
    chk("rst_outs", 64'({rd_addr, out_idx, out_data, out_last, done}), 64'd0);
`ifdef REGDUMP_CHECKSUM_EN
    chk("rst_checksum", 64'(checksum), 64'd0);
`endif
    #9 rst_n = 1'b1;
    tick();

    // 1: full dump, with an ignored start while busy
    push_dump(1'b0, DataW'(32'h44));
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_first_addr", 64'({rd_req, rd_addr}), 64'({1'b1, 5'd0}));
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(1'b0, 200, cyc);
    chk("t1_cycles", 64'(cyc + 5), 64'd64);
    tick();
    chk("t1_done_1cyc", 64'({done, busy}), 64'd0);
    chk("t1_addr_held", 64'(rd_addr), 64'd31);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // 2: SKIP_ZERO instance
    push_dump(1'b1, DataW'(32'h44));
    start_s = 1'b1; tick(); start_s = 1'b0;
    chk("t2_first_addr", 64'(rd_addr_s), 64'd1);
    wait_done(1'b1, 200, cyc);
    chk("t2_cycles", 64'(cyc), 64'd62);
    tick();
    chk("t2_queue_empty", 64'(exp_s.size()), 64'd0);

    // 4 + 3: grant denial at idx 4 (r4 rewritten), backpressure at idx 7
    push_dump(1'b0, DataW'(32'hDEAD));
    start = 1'b1; tick(); start = 1'b0;
    for (t = 0; t < 100 && !(rd_req && rd_addr == 5'd4); t++) tick();
    chk("t4_reach_idx4", 64'(rd_addr), 64'd4);
    gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) regs[4] = DataW'(32'hDEAD);
      chk("t4_req_held", 64'({rd_req, rd_addr, out_valid}), 64'({1'b1, 5'd4, 1'b0}));
    end
    gnt = 1'b1;
    for (t = 0; t < 100 && !(out_valid && out_idx == 5'd7); t++) tick();
    chk("t3_reach_idx7", 64'(out_idx), 64'd7);
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold", 64'({out_valid, out_idx, out_data, rd_req}),
          64'({1'b1, 5'd7, 32'h77, 1'b0}));
    end
    ready = 1'b1;
    tick();
    chk("t3_idx8_after_accept", 64'({rd_req, rd_addr}), 64'({1'b1, 5'd8}));
    wait_done(1'b0, 200, cyc);
    tick();
    chk("t34_queue_empty", 64'(exp_q.size()), 64'd0);
    regs[4] = DataW'(32'h44);

    // 5: abort at idx 10, abort+start in idle, restart, reset mid-dump
    push_dump(1'b0, DataW'(32'h44));
    start = 1'b1; tick(); start = 1'b0;
    for (t = 0; t < 100 && !(out_valid && out_idx == 5'd10); t++) tick();
    chk("t5_reach_idx10", 64'(out_idx), 64'd10);
    abort = 1'b1; ready = 1'b0;
    tick();
    chk("t5_abort", 64'({out_valid, busy, rd_req, done}), 64'd0);
    exp_q.delete();
    abort = 1'b0; ready = 1'b1;
    tick();
    chk("t5_no_done", 64'(done), 64'd0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("t5_abort_wins", 64'(busy), 64'd0);
    push_dump(1'b0, DataW'(32'h44));
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_restart_idx0", 64'({rd_req, rd_addr}), 64'({1'b1, 5'd0}));
    for (t = 0; t < 100 && !(out_valid && out_idx == 5'd5); t++) tick();
    chk("t5_reach_idx5", 64'(out_idx), 64'd5);
    ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("t5_reset_now", 64'({out_valid, busy, rd_req, done, out_last}), 64'd0);
    chk("t5_reset_regs", 64'({rd_addr, out_idx, out_data}), 64'd0);
    exp_q.delete();
    #2 rst_n = 1'b1; ready = 1'b1;
    tick();

`ifdef REGDUMP_CHECKSUM_EN
    // 6: checksum of 32 x 0xFFFFFFFF, after a nonzero earlier sum is cleared
    for (int i = 0; i < NumRegs; i++) regs[i] = '1;
    push_dump(1'b0, DataW'(32'h44));
    for (int i = 0; i < NumRegs; i++) exp_q[i].data = '1;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(1'b0, 200, cyc);
    chk("t6_checksum", 64'(checksum), 64'hFFFF_FFE0);
    tick();
    chk("t6_checksum_stable", 64'(checksum), 64'hFFFF_FFE0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
